// File: rtl/video_write_scheduler_if.sv
// video_write_scheduler_if: TPU, fill-engine and video-memory write port bundle
interface video_write_scheduler_if;
  logic        hold;
  logic        tpu_req;
  logic [15:0] tpu_address;
  logic [23:0] tpu_value;
  logic [23:0] tpu_mask;
  logic        tpu_ack;
  logic        fill_start;
  logic [15:0] fill_base;
  logic [15:0] fill_count;
  logic [23:0] fill_value;
  logic [23:0] fill_mask;
  logic        fill_busy;
  logic        fill_done;
  logic        video_write;
  logic [15:0] video_address;
  logic [23:0] video_value;
  logic [23:0] video_mask;
  modport master (
    output hold, tpu_req, tpu_address, tpu_value, tpu_mask,
    output fill_start, fill_base, fill_count, fill_value, fill_mask,
    input  tpu_ack, fill_busy, fill_done,
    input  video_write, video_address, video_value, video_mask
  );
  modport slave (
    input  hold, tpu_req, tpu_address, tpu_value, tpu_mask,
    input  fill_start, fill_base, fill_count, fill_value, fill_mask,
    output tpu_ack, fill_busy, fill_done,
    output video_write, video_address, video_value, video_mask
  );
endinterface

// File: rtl/video_write_scheduler.sv
// video_write_scheduler: round-robin TPU/linear-fill sharing of the video write port; fill engine built only with VIDEO_SCHED_FILL_EN
module video_write_scheduler (
  input logic                   clk,
  input logic                   reset,
  video_write_scheduler_if.slave bus
);
  logic        tpu_t, grant_t, grant_f;
  logic [15:0] fill_a;
  logic [23:0] fill_v, fill_m;
  logic        write_q, write_d, ack_q;
  logic [15:0] addr_q, addr_d;
  logic [23:0] value_q, value_d, mask_q, mask_d;
  // The ack cycle masks the request so one request yields exactly one write
  assign tpu_t = bus.tpu_req & ~ack_q;
`ifdef VIDEO_SCHED_FILL_EN
  typedef enum logic [1:0] {IDLE, RUN, DONE} fill_state_t;
  fill_state_t state_q, state_d;
  logic [15:0] faddr_q, faddr_d, rem_q, rem_d;
  logic [23:0] fval_q, fval_d, fmask_q, fmask_d;
  logic        last_q, last_d, fill_f;
  assign fill_f  = (state_q == RUN) && (rem_q != 16'd0);
  assign grant_t = ~bus.hold & tpu_t & (~fill_f | last_q);
  assign grant_f = ~bus.hold & fill_f & ~grant_t;
  // Fill engine state and round-robin pointer (last_q=1: fill granted last)
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      faddr_q <= '0;
      rem_q   <= '0;
      fval_q  <= '0;
      fmask_q <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      faddr_q <= faddr_d;
      rem_q   <= rem_d;
      fval_q  <= fval_d;
      fmask_q <= fmask_d;
      last_q  <= last_d;
    end
  end
  // Fill next state: latch payload on an idle start, step per fill grant, finish after the last write cycle
  always_comb begin
    state_d = state_q;
    faddr_d = faddr_q;
    rem_d   = rem_q;
    fval_d  = fval_q;
    fmask_d = fmask_q;
    last_d  = grant_t ? 1'b0 : (grant_f ? 1'b1 : last_q);
    case (state_q)
      IDLE: if (bus.fill_start) begin
        state_d = (bus.fill_count == 16'd0) ? DONE : RUN;
        faddr_d = bus.fill_base;
        rem_d   = bus.fill_count;
        fval_d  = bus.fill_value;
        fmask_d = bus.fill_mask;
      end
      RUN: begin
        faddr_d = grant_f ? faddr_q + 16'd1 : faddr_q;
        rem_d   = grant_f ? rem_q - 16'd1 : rem_q;
        state_d = (rem_q == 16'd0) ? DONE : RUN;
      end
      default: state_d = IDLE;
    endcase
  end
  assign bus.fill_busy = (state_q == RUN);
  assign bus.fill_done = (state_q == DONE);
  assign fill_a = faddr_q;
  assign fill_v = fval_q;
  assign fill_m = fmask_q;
`else
  assign grant_t       = ~bus.hold & tpu_t;
  assign grant_f       = 1'b0;
  assign bus.fill_busy = 1'b0;
  assign bus.fill_done = 1'b0;
  assign fill_a        = '0;
  assign fill_v        = '0;
  assign fill_m        = '0;
`endif
  // Write port next value: granted payload, otherwise hold the last one
  always_comb begin
    write_d = grant_t | grant_f;
    addr_d  = grant_t ? bus.tpu_address : (grant_f ? fill_a : addr_q);
    value_d = grant_t ? bus.tpu_value : (grant_f ? fill_v : value_q);
    mask_d  = grant_t ? bus.tpu_mask : (grant_f ? fill_m : mask_q);
  end
  // Registered write port and ack
  always_ff @(posedge clk) begin
    if (reset) begin
      write_q <= 1'b0;
      ack_q   <= 1'b0;
      addr_q  <= '0;
      value_q <= '0;
      mask_q  <= '0;
    end else begin
      write_q <= write_d;
      ack_q   <= grant_t;
      addr_q  <= addr_d;
      value_q <= value_d;
      mask_q  <= mask_d;
    end
  end
  assign bus.video_write   = write_q;
  assign bus.tpu_ack       = ack_q;
  assign bus.video_address = addr_q;
  assign bus.video_value   = value_q;
  assign bus.video_mask    = mask_q;
endmodule

// File: doc/video_write_scheduler.md
# video_write_scheduler

Shares the single video-memory write port (write, 16-bit address, 24-bit value, 24-bit mask) between the TPU and an internal rectangular-free linear fill engine used for clear-screen and attribute sweeps. Sits between `tpu` and `video_memory` in the top level. Arbitrates round-robin, keeps writes out of the character-fetch read slot and registers every output.

## Interface
- No parameters; widths fixed: address 16, value 24, mask 24, fill count 16.
- `clk` in 1: system clock; the only clock.
- `reset` in 1: synchronous, active-high reset.
- `hold` in 1: video-memory read slot strobe (top level connects `clk_load_char`); no grant is issued in a cycle with `hold`=1.
- `tpu_req` in 1: TPU write request; held with payload stable until `tpu_ack`.
- `tpu_address` in 16, `tpu_value` in 24, `tpu_mask` in 24: TPU write payload.
- `tpu_ack` out 1: one-cycle pulse, coincident with the issued write.
- `fill_start` in 1: one-cycle pulse; latches fill payload when `fill_busy`=0.
- `fill_base` in 16, `fill_count` in 16, `fill_value` in 24, `fill_mask` in 24: fill payload.
- `fill_busy` out 1: fill in progress.
- `fill_done` out 1: one-cycle pulse after last fill write.
- `video_write` out 1, `video_address` out 16, `video_value` out 24, `video_mask` out 24: registered memory write port.

## Operation
- Requesters per cycle: T = `tpu_req` & ~`tpu_ack`; F = `fill_busy` & remaining≠0.
- No grant when `hold`=1. Otherwise: only T → TPU; only F → fill; both → port not granted last (`last` pointer, updated on every grant).
- TPU grant: next cycle `video_write`=1 with TPU payload and `tpu_ack`=1. The ack cycle masks T, so the TPU cannot be granted twice on one request.
- Fill grant: next cycle `video_write`=1 with current fill address, latched value/mask; address += 1 (wraps 0xFFFF→0x0000), remaining −= 1.
- Fill FSM: IDLE → (`fill_start`, count≠0) → RUN → (last write issued) → DONE (1 cycle: `fill_done`=1, `fill_busy`=0) → IDLE. `fill_start` with count=0: IDLE → DONE directly, no write. `fill_start` in RUN or DONE ignored.
- `fill_busy`=1 from the cycle after accepted `fill_start` through the cycle carrying the last fill write.
- No grant cycle: `video_write`=0; address/value/mask hold their last values.

## Timing
- Reset: `video_write`, `tpu_ack`, `fill_busy`, `fill_done`=0; `video_address`/`video_value`/`video_mask`=0; fill FSM IDLE, remaining 0; `last`=fill (TPU wins first tie). Reset mid-fill aborts it without `fill_done`.
- Latency: grant cycle N → write/ack on N+1. Uncontended TPU: one write per 2 cycles. Uncontended fill: one write per cycle.
- Both active, no `hold`: strictly alternating writes, TPU, fill, TPU, …
- `hold` does not affect the write already registered for the current cycle; it only blocks a grant. Arbitration order resumes unchanged after `hold`.
- Fill of n words, no contention, no hold: writes on cycles S+2…S+n+1 (S = `fill_start` cycle), `fill_done` on S+n+2.

## Configuration
- `VIDEO_SCHED_FILL_EN` defined: fill engine and round-robin compiled in as above.
- Not defined: fill ports are ignored, `fill_busy`/`fill_done` tied 0, F always 0; block is a TPU pass-through register with `hold` gating and the same ack timing.

## Test plan
- Reset, then TPU req addr 0x0123 value 0xABCDEF mask 0xFFFFFF → write/ack exactly one cycle later with that payload; one write only while req stays high through ack.
- Fill base 0x1000 count 4 value 0x000007 mask 0x00000F, TPU idle → writes to 0x1000..0x1003 on consecutive cycles, `fill_done` one cycle after 0x1003, `fill_busy` then 0.
- Fill base 0xFFFE count 3 → addresses 0xFFFE, 0xFFFF, 0x0000.
- Fill count 8 with TPU requesting continuously → writes alternate TPU/fill starting with TPU; fill completes after 8 fill writes.
- `hold` pulsed high 1 cycle every 8 during a fill count 16 → no write in the cycle after each `hold`, all 16 addresses written once in order.
- Fill count 0 → no write, `fill_done` on cycle S+1; `fill_start` during RUN ignored; reset mid-fill → all outputs 0, no `fill_done`.
